ycbcr_to_rgb: RTL and testbench

YCBCR_TO_RGB -- requirements
Module: ycbcr_to_rgb

---
 rtl/ycbcr_to_rgb_pkg.sv | 17 +
 rtl/ycc_clamp.sv | 36 +++
 rtl/ycbcr_to_rgb.sv | 149 ++++++++++++++
 tb/tb_ycbcr_to_rgb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_to_rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ycbcr_to_rgb_pkg
// Brief  : Q12 conversion coefficients and rounding constants for ycbcr_to_rgb.
// Rev    : 1.0 - initial release
// ============================================================================
package ycbcr_to_rgb_pkg;

  localparam int C_KR    = 5743;
  localparam int C_KGB   = 1410;
  localparam int C_KGR   = 2925;
  localparam int C_KB    = 7258;
  localparam int C_ROUND = 2048;
  localparam int C_SHIFT = 12;

endpackage
`default_nettype wire

// File: rtl/ycc_clamp.sv
`default_nettype none
// ============================================================================
// Module : ycc_clamp
// Brief  : Rounds a signed Q12 sum to an integer and saturates it to the
//          unsigned colour range.
// Rev    : 1.0 - initial release
// ============================================================================
module ycc_clamp
  import ycbcr_to_rgb_pkg::*;
#(
  parameter int COLOR_PRECISION = 8,
  parameter int SUM_W           = COLOR_PRECISION + 16
) (
  input  logic signed [SUM_W-1:0]           i_sum,
  output logic        [COLOR_PRECISION-1:0] o_val
);

  localparam logic signed [SUM_W-1:0] ROUND_W = SUM_W'(C_ROUND);

  logic signed [SUM_W-1:0] w_rnd;
  logic signed [SUM_W-1:0] w_shr;

  assign w_rnd = i_sum + ROUND_W;
  assign w_shr = w_rnd >>> C_SHIFT;

  always_comb begin
    o_val = w_shr[COLOR_PRECISION-1:0];
    if (w_shr[SUM_W-1]) begin
      o_val = '0;
    end else if (|w_shr[SUM_W-2:COLOR_PRECISION]) begin
      o_val = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module : ycbcr_to_rgb
// Brief  : 3-stage JFIF YCbCr to RGB converter with a global stall enable.
//          Optional frame-start sideband enabled by YCBCR_TO_RGB_SOF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module ycbcr_to_rgb
  import ycbcr_to_rgb_pkg::*;
#(
  parameter int COLOR_PRECISION = 8
) (
  input  logic                       i_arst,
  input  logic                       i_sysclk,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [COLOR_PRECISION-1:0] i_Y,
  input  logic [COLOR_PRECISION-1:0] i_Cb,
  input  logic [COLOR_PRECISION-1:0] i_Cr,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [COLOR_PRECISION-1:0] o_R,
  output logic [COLOR_PRECISION-1:0] o_G,
  output logic [COLOR_PRECISION-1:0] o_B
`ifdef YCBCR_TO_RGB_SOF_EN
  ,
  input  logic                       i_sof,
  output logic                       o_sof
`endif
);

  localparam int SUM_W = COLOR_PRECISION + 16;
  localparam logic [COLOR_PRECISION:0] OFS = {2'b01, {(COLOR_PRECISION-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] KR_W  = SUM_W'(C_KR);
  localparam logic signed [SUM_W-1:0] KGB_W = SUM_W'(C_KGB);
  localparam logic signed [SUM_W-1:0] KGR_W = SUM_W'(C_KGR);
  localparam logic signed [SUM_W-1:0] KB_W  = SUM_W'(C_KB);

  logic w_en;
  logic r_s1_valid;
  logic r_s2_valid;
  logic r_o_valid;

  logic        [COLOR_PRECISION-1:0] r_s1_y;
  logic signed [COLOR_PRECISION:0]   r_s1_cb;
  logic signed [COLOR_PRECISION:0]   r_s1_cr;

  logic signed [SUM_W-1:0] w_y_q12;
  logic signed [SUM_W-1:0] w_cb_ext;
  logic signed [SUM_W-1:0] w_cr_ext;
  logic signed [SUM_W-1:0] w_sum_r;
  logic signed [SUM_W-1:0] w_sum_g;
  logic signed [SUM_W-1:0] w_sum_b;
  logic signed [SUM_W-1:0] r_s2_r;
  logic signed [SUM_W-1:0] r_s2_g;
  logic signed [SUM_W-1:0] r_s2_b;

  logic [COLOR_PRECISION-1:0] w_clamp_r;
  logic [COLOR_PRECISION-1:0] w_clamp_g;
  logic [COLOR_PRECISION-1:0] w_clamp_b;
  logic [COLOR_PRECISION-1:0] r_o_r;
  logic [COLOR_PRECISION-1:0] r_o_g;
  logic [COLOR_PRECISION-1:0] r_o_b;

  // The whole pipeline moves as one unit whenever the output slot can be freed.
  assign w_en    = ~r_o_valid | i_ready;
  assign o_ready = w_en;
  assign o_valid = r_o_valid;
  assign o_R     = r_o_r;
  assign o_G     = r_o_g;
  assign o_B     = r_o_b;

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_r      <= '0;
      r_o_g      <= '0;
      r_o_b      <= '0;
    end else if (w_en) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      r_o_valid  <= r_s2_valid;
      r_o_r      <= w_clamp_r;
      r_o_g      <= w_clamp_g;
      r_o_b      <= w_clamp_b;
    end
  end

  // Unsigned subtraction in COLOR_PRECISION+1 bits yields the two's-complement chroma.
  always_ff @(posedge i_sysclk) begin
    if (w_en) begin
      r_s1_y  <= i_Y;
      r_s1_cb <= $signed({1'b0, i_Cb} - OFS);
      r_s1_cr <= $signed({1'b0, i_Cr} - OFS);
      r_s2_r  <= w_sum_r;
      r_s2_g  <= w_sum_g;
      r_s2_b  <= w_sum_b;
    end
  end

  assign w_y_q12  = $signed({{(SUM_W-COLOR_PRECISION){1'b0}}, r_s1_y}) <<< C_SHIFT;
  assign w_cb_ext = {{(SUM_W-COLOR_PRECISION-1){r_s1_cb[COLOR_PRECISION]}}, r_s1_cb};
  assign w_cr_ext = {{(SUM_W-COLOR_PRECISION-1){r_s1_cr[COLOR_PRECISION]}}, r_s1_cr};

  assign w_sum_r = w_y_q12 + KR_W * w_cr_ext;
  assign w_sum_g = w_y_q12 - KGB_W * w_cb_ext - KGR_W * w_cr_ext;
  assign w_sum_b = w_y_q12 + KB_W * w_cb_ext;

  ycc_clamp #(.COLOR_PRECISION(COLOR_PRECISION), .SUM_W(SUM_W)) u_clamp_r (
    .i_sum (r_s2_r),
    .o_val (w_clamp_r)
  );

  ycc_clamp #(.COLOR_PRECISION(COLOR_PRECISION), .SUM_W(SUM_W)) u_clamp_g (
    .i_sum (r_s2_g),
    .o_val (w_clamp_g)
  );

  ycc_clamp #(.COLOR_PRECISION(COLOR_PRECISION), .SUM_W(SUM_W)) u_clamp_b (
    .i_sum (r_s2_b),
    .o_val (w_clamp_b)
  );

`ifdef YCBCR_TO_RGB_SOF_EN
  logic r_s1_sof;
  logic r_s2_sof;
  logic r_o_sof;

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      r_s1_sof <= 1'b0;
      r_s2_sof <= 1'b0;
      r_o_sof  <= 1'b0;
    end else if (w_en) begin
      r_s1_sof <= i_sof & i_valid;
      r_s2_sof <= r_s1_sof;
      r_o_sof  <= r_s2_sof & r_s2_valid;
    end
  end

  assign o_sof = r_o_sof & r_o_valid;
`else
  // No frame-start marker is carried in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module : tb_ycbcr_to_rgb
// Brief  : Directed and randomised handshake bench for ycbcr_to_rgb.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ycbcr_to_rgb;

  logic       i_arst;
  logic       i_sysclk;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_Y;
  logic [7:0] i_Cb;
  logic [7:0] i_Cr;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_R;
  logic [7:0] o_G;
  logic [7:0] o_B;
  logic       i_sof;
`ifdef YCBCR_TO_RGB_SOF_EN
  logic       o_sof;
`endif

  int checks   = 0;
  int failures = 0;

  ycbcr_to_rgb #(.COLOR_PRECISION(8)) dut (
    .i_arst   (i_arst),
    .i_sysclk (i_sysclk),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_Y      (i_Y),
    .i_Cb     (i_Cb),
    .i_Cr     (i_Cr),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_R      (o_R),
    .o_G      (o_G),
    .o_B      (o_B)
`ifdef YCBCR_TO_RGB_SOF_EN
    ,
    .i_sof    (i_sof),
    .o_sof    (o_sof)
`endif
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clip(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [23:0] model(input int y, input int cb, input int cr);
    int r, g, b;
    r = (y * 4096 + 5743 * (cr - 128) + 2048) >>> 12;
    g = (y * 4096 - 1410 * (cb - 128) - 2925 * (cr - 128) + 2048) >>> 12;
    b = (y * 4096 + 7258 * (cb - 128) + 2048) >>> 12;
    return {clip(r), clip(g), clip(b)};
  endfunction

  // One pixel through an idle pipeline; result must appear exactly 3 cycles later.
  task automatic directed(input string tag, input logic [7:0] y, input logic [7:0] cb,
                          input logic [7:0] cr, input logic [23:0] exp);
    i_Y = y; i_Cb = cb; i_Cr = cr; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    check({tag, "_early"}, {31'd0, o_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_rgb"}, {8'd0, o_R, o_G, o_B}, {8'd0, exp});
    tick();
  endtask

  logic [24:0] q[$];
  logic [24:0] exp_e;
  logic [23:0] prev_rgb;
  logic        stall_prev;
  logic        pend;
  logic [7:0]  py, pcb, pcr;
  int          acc, got, sent, recv;
  logic        seen;

  initial begin
    i_arst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_Y = 8'd0; i_Cb = 8'd0; i_Cr = 8'd0; i_sof = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_rgb", {8'd0, o_R, o_G, o_B}, 32'd0);
    i_arst = 1'b0; i_ready = 1'b1;
    tick();

    directed("grey",  8'd128, 8'd128, 8'd128, 24'h808080);
    directed("red",   8'd255, 8'd128, 8'd255, 24'hFFA4FF);
    directed("dark",  8'd0,   8'd128, 8'd0,   24'h005B00);
    directed("blue",  8'd0,   8'd255, 8'd128, 24'h0000E1);

    // Reset with one pixel at the output and two more in flight.
    i_Y = 8'd255; i_Cb = 8'd128; i_Cr = 8'd255; i_valid = 1'b1;
    tick();
    i_Y = 8'd128; i_Cb = 8'd128; i_Cr = 8'd128;
    tick();
    i_Y = 8'd0; i_Cb = 8'd128; i_Cr = 8'd0;
    tick();
    i_valid = 1'b0;
    check("prerst_valid", {31'd0, o_valid}, 32'd1);
    check("prerst_rgb", {8'd0, o_R, o_G, o_B}, 32'h00FFA4FF);
    i_arst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_rgb", {8'd0, o_R, o_G, o_B}, 32'd0);
    tick();
    i_arst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | o_valid;
    end
    check("postrst_nooutput", {31'd0, seen}, 32'd0);

    // Six back-to-back grey pixels (R=G=B=Y) with the sink stalled from cycle 2.
    acc = 0; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      i_ready = (c < 2) || (c >= 10);
      i_valid = (acc < 6);
      i_Y = 8'(20 + 10 * acc); i_Cb = 8'd128; i_Cr = 8'd128;
      #1;
      if (c == 5) begin
        check("stall_ready", {31'd0, o_ready}, 32'd0);
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        check("stall_accepted", 32'(acc), 32'd3);
        check("stall_rgb5", {8'd0, o_R, o_G, o_B}, 32'h00141414);
      end
      if (c == 9) check("stall_rgb9", {8'd0, o_R, o_G, o_B}, 32'h00141414);
      if (o_valid && i_ready) begin
        check("stall_order", {8'd0, o_R, o_G, o_B},
              {8'd0, {3{8'(20 + 10 * got)}}});
        got++;
      end
      if (i_valid && o_ready) acc++;
      tick();
    end
    i_valid = 1'b0;
    check("stall_delivered", 32'(got), 32'd6);

    // Randomised handshake against the reference model.
    sent = 0; recv = 0; pend = 1'b0; stall_prev = 1'b0; prev_rgb = '0;
    py = '0; pcb = '0; pcr = '0;
    for (int cyc = 0; cyc < 60000 && recv < 10000; cyc++) begin
      if (!pend && sent < 10000) begin
        py  = 8'($urandom_range(0, 255));
        pcb = 8'($urandom_range(0, 255));
        pcr = 8'($urandom_range(0, 255));
        pend = 1'b1;
      end
      i_valid = pend && ($urandom_range(0, 99) < 70);
      i_Y = py; i_Cb = pcb; i_Cr = pcr;
      i_sof = (sent == 0);
      i_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (stall_prev) check("rand_hold", {8'd0, o_R, o_G, o_B}, {8'd0, prev_rgb});
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("rand_extra", {31'd0, o_valid}, 32'd0);
        end else begin
          exp_e = q.pop_front();
          check("rand_rgb", {8'd0, o_R, o_G, o_B}, {8'd0, exp_e[23:0]});
`ifdef YCBCR_TO_RGB_SOF_EN
          check("rand_sof", {31'd0, o_sof}, {31'd0, exp_e[24]});
`endif
        end
        recv++;
      end
      if (i_valid && o_ready) begin
        q.push_back({i_sof, model(int'(py), int'(pcb), int'(pcr))});
        sent++;
        pend = 1'b0;
      end
      stall_prev = o_valid && !i_ready;
      prev_rgb = {o_R, o_G, o_B};
      tick();
    end
    i_valid = 1'b0;
    check("rand_received", 32'(recv), 32'd10000);
    check("rand_leftover", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
